// File: rtl/bram_test_ctrl.sv
// bram_test_ctrl: write/read-back self test for a simple dual-port block RAM.
// Each address is written with (seed + addr), then read back through port B.
// The returned words are compared against the same pattern, and the mismatches
// are counted. The RAM read latency is covered by a tagged valid/address delay line.
module bram_test_ctrl #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_cnt,
  output logic [ADDR_W-1:0] err_addr,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   addr;
  logic [2:0]          drain_cnt;
  logic [DATA_W-1:0]   seed_q;
  logic [ADDR_W:0]     err_cnt_q;
  logic [ADDR_W:0]     err_cnt_nxt;
  logic [ADDR_W-1:0]   err_addr_q;
  logic                first_seen;
  logic                pass_q;
  logic [RD_LAT-1:0]   pipe_vld;
  logic [ADDR_W-1:0]   pipe_addr [RD_LAT];
  logic                last_addr;
  logic                drain_last;
  logic                ret_vld;
  logic [ADDR_W-1:0]   ret_addr;
  logic [DATA_W-1:0]   ret_exp;
  logic                mismatch;

  assign last_addr   = &addr;
  assign drain_last  = (drain_cnt == 3'(RD_LAT - 1));
  assign ret_vld     = pipe_vld[RD_LAT-1];
  assign ret_addr    = pipe_addr[RD_LAT-1];
  assign ret_exp     = seed_q + DATA_W'(ret_addr);
  assign mismatch    = ret_vld && (ram_rdata != ret_exp);
  assign err_cnt_nxt = err_cnt_q + {{ADDR_W{1'b0}}, mismatch};
  assign err_cnt     = err_cnt_q;
  assign err_addr    = err_addr_q;

  // State register; reset always returns to IDLE, which aborts a running test
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and RAM/status outputs; addresses and write data are zero outside their phase
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    pass      = pass_q;
    ram_we    = 1'b0;
    ram_waddr = '0;
    ram_wdata = '0;
    ram_raddr = '0;
    case (state)
      IDLE: begin
        if (start) state_nxt = WRITE;
      end
      WRITE: begin
        busy      = 1'b1;
        ram_we    = 1'b1;
        ram_waddr = addr;
        ram_wdata = seed_q + DATA_W'(addr);
        if (last_addr) state_nxt = READ;
      end
      READ: begin
        busy      = 1'b1;
        ram_raddr = addr;
        if (last_addr) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        pass      = (err_cnt_nxt == '0);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address/drain counters, seed latch and error bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      addr       <= '0;
      drain_cnt  <= '0;
      seed_q     <= '0;
      err_cnt_q  <= '0;
      err_addr_q <= '0;
      first_seen <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      if (mismatch) begin
        err_cnt_q <= err_cnt_nxt;
        if (!first_seen) begin
          err_addr_q <= ret_addr;
          first_seen <= 1'b1;
        end
      end
      case (state)
        IDLE: begin
          addr      <= '0;
          drain_cnt <= '0;
          if (start) begin
            seed_q     <= seed;
            err_cnt_q  <= '0;
            err_addr_q <= '0;
            first_seen <= 1'b0;
            pass_q     <= 1'b0;
          end
        end
        WRITE, READ: addr <= addr + 1'b1;
        DRAIN:       drain_cnt <= drain_cnt + 1'b1;
        DONE: begin
          pass_q    <= (err_cnt_nxt == '0);
          drain_cnt <= '0;
        end
        default: addr <= '0;
      endcase
    end
  end

  // Delay line tagging each issued read so its data is checked when the RAM returns it
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_addr[i] <= '0;
    end else begin
      pipe_vld[0]  <= (state == READ);
      pipe_addr[0] <= addr;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_addr[i] <= pipe_addr[i-1];
      end
    end
  end

endmodule

// File: doc/bram_test_ctrl.md
BRAM_TEST_CTRL -- requirements
Module: bram_test_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 9, giving the RAM address width (depth 2^ADDR_W = 512 words).
REQ-002 The block SHALL have parameter DATA_W, default 16, giving the RAM word width.
REQ-003 The block SHALL have parameter RD_LAT, default 1, giving the RAM port-B read latency in clocks (range 1..4).
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  one-cycle request to run a full write/read-back test.
REQ-007 seed  input  DATA_W  pattern seed, sampled on an accepted start.
REQ-008 busy  output  1  high while a test is running.
REQ-009 done  output  1  one-cycle pulse at test completion.
REQ-010 pass  output  1  result of the last completed test; 1 = zero mismatches.
REQ-011 err_cnt  output  ADDR_W+1  number of mismatching words in the last or current test.
REQ-012 err_addr  output  ADDR_W  address of the first mismatch; 0 when none.
REQ-013 ram_we  output  1  port-A write enable.
REQ-014 ram_waddr  output  ADDR_W  port-A write address.
REQ-015 ram_wdata  output  DATA_W  port-A write data.
REQ-016 ram_raddr  output  ADDR_W  port-B read address.
REQ-017 ram_rdata  input  DATA_W  port-B read data, valid RD_LAT cycles after ram_raddr.

Function
REQ-018 The FSM SHALL have states IDLE, WRITE, READ, DRAIN, DONE.
REQ-019 Expected data for address a SHALL be (seed_latched + a) mod 2^DATA_W, a zero-extended.
REQ-020 A start sampled high in IDLE SHALL latch seed, clear err_cnt and err_addr and the first-error flag, and enter WRITE on the next cycle; start in any other state SHALL be ignored.
REQ-021 In WRITE, ram_we SHALL be 1 with ram_waddr stepping 0..2^ADDR_W-1 one per cycle, and ram_wdata equal to the pattern for ram_waddr; after the last address the FSM SHALL enter READ.
REQ-022 In READ, ram_raddr SHALL step 0..2^ADDR_W-1 one per cycle with ram_we = 0; after the last address the FSM SHALL enter DRAIN.
REQ-023 A valid/address delay line of depth RD_LAT SHALL tag each issued read; when a tagged word returns, ram_rdata SHALL be compared with the expected pattern for its address.
REQ-024 On a mismatch, err_cnt SHALL increment by 1; err_addr SHALL be loaded only on the first mismatch of the test.
REQ-025 DRAIN SHALL last exactly RD_LAT cycles so that every issued read is compared, then enter DONE.
REQ-026 DONE SHALL last one cycle with done = 1 and pass = (err_cnt == 0) including any compare retiring that cycle; the FSM then returns to IDLE.
REQ-027 busy SHALL be 1 in WRITE, READ and DRAIN, and 0 in IDLE and DONE.
REQ-028 ram_we SHALL be 0 in every state except WRITE; ram_waddr and ram_raddr SHALL hold 0 outside WRITE and READ respectively.
REQ-029 pass, err_cnt and err_addr SHALL hold their values from the end of a test until the next accepted start.
REQ-030 Latency: with start accepted at cycle k, WRITE SHALL occupy cycles k+1..k+2^ADDR_W, READ k+2^ADDR_W+1..k+2^(ADDR_W+1), and done SHALL pulse at cycle k+2^(ADDR_W+1)+RD_LAT+1.

Reset
REQ-031 While rst = 1 the FSM SHALL enter IDLE; busy, done, pass, ram_we, err_cnt, err_addr, ram_waddr, ram_raddr and ram_wdata SHALL be 0; the delay line SHALL be cleared.
REQ-032 rst asserted mid-test SHALL abort the test with no done pulse, and in-flight reads SHALL not be compared.
REQ-033 rst SHALL take priority over start in the same cycle.

Verification
REQ-034 Ideal RAM model (RD_LAT = 1), seed = 16'h1234, start at cycle 0 -> 512 writes with addr 5 written with 16'h1239; done at cycle 1026; pass = 1, err_cnt = 0, err_addr = 0.
REQ-035 Model corrupts read data at addrs 5 and 300 -> err_cnt = 2, err_addr = 5, pass = 0.
REQ-036 seed = 16'hFFFF -> ram_wdata = 16'hFFFF at addr 0 and 16'h0000 at addr 1 (wrap); test passes.
REQ-037 Stuck-at-zero read data, seed = 0 -> err_cnt = 511, err_addr = 1, pass = 0.
REQ-038 start pulsed again during READ -> ignored, with single done at the nominal cycle; rst during WRITE at addr 100 -> all outputs 0 next cycle, no done, and a new start runs a clean pass.
REQ-039 RD_LAT = 3 with matching model -> done at cycle 1028, pass = 1.
